// File: rtl/pipe_pkg.sv
// pipe_pkg: stage indices, default payload width and payload field layout
// shared by the pipeline chain and the stage logic that packs payloads.
package pipe_pkg;

  localparam int PIPE_IF  = 0;
  localparam int PIPE_ID  = 1;
  localparam int PIPE_EX  = 2;
  localparam int PIPE_MEM = 3;
  localparam int PIPE_WB  = 4;

  localparam int PIPE_W = 64;

  localparam int PL_PC_LSB        = 0;
  localparam int PL_PC_W          = 32;
  localparam int PL_DEST_LSB      = 32;
  localparam int PL_DEST_W        = 5;
  localparam int PL_GR_WE_BIT     = 37;
  localparam int PL_RES_FROM_MEM  = 38;

  // Out-of-range requesting stages collapse onto the oldest stage.
  function automatic int clamp_stage(int k, int n);
    return (k >= n) ? n - 1 : k;
  endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// pipe_chain_if: valid/allowin payload handshake between the chain and
// its producer (fetch) or consumer (writeback).
interface pipe_chain_if #(
  parameter int W = 64
);
  logic         valid;
  logic [W-1:0] data;
  logic         allowin;

  modport master (
    output valid,
    output data,
    input  allowin
  );

  modport slave (
    input  valid,
    input  data,
    output allowin
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register, a valid bit plus payload,
// with squash over advance over hold.
module pipe_stage_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         squash,
  input  logic         allowin,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Valid follows squash/advance/hold; payload loads only on a real arrival.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (squash) begin
        valid <= 1'b0;
      end else if (allowin) begin
        valid <= in_valid;
      end
      if (allowin && in_valid && !squash) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: N-stage in-order pipeline skeleton with valid/allowin
// backpressure and redirect squash; PIPE_PERF_CNT_EN adds stall/flush counters.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int W      = PIPE_W,
  localparam int SW    = $clog2(NSTAGE)
) (
  input  logic                clk,
  input  logic                reset,
  pipe_chain_if.slave         in_if,
  input  logic [NSTAGE-1:0]   ready_go,
  input  logic [NSTAGE*W-1:0] stage_next_data,
  output logic [NSTAGE-1:0]   stage_valid,
  output logic [NSTAGE*W-1:0] stage_data,
  input  logic                redirect_valid,
  input  logic [SW-1:0]       redirect_stage,
  pipe_chain_if.master        out_if
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [NSTAGE*32-1:0] perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  logic [NSTAGE:0]   allowin;
  logic [NSTAGE-1:0] to_next;
  logic [NSTAGE-1:0] squash;
  logic [NSTAGE-1:0] inc_valid;
  logic [W-1:0]      inc_data [NSTAGE];
  int                kc;

  assign kc = clamp_stage(int'(redirect_stage), NSTAGE);

  assign allowin[NSTAGE] = out_if.allowin;
  assign in_if.allowin   = allowin[0];
  assign out_if.valid    = to_next[NSTAGE-1];
  assign out_if.data     = stage_next_data[(NSTAGE-1)*W +: W];

  // Producer input is blocked whenever a redirect is in flight.
  assign inc_valid[0] = in_if.valid & ~redirect_valid;
  assign inc_data[0]  = in_if.data;

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    assign to_next[i] = stage_valid[i] & ready_go[i];
    assign allowin[i] = ~stage_valid[i] |
                        (ready_go[i] & allowin[i+1]);
    assign squash[i]  = redirect_valid & (i < kc);

    if (i > 0) begin : g_link
      assign inc_valid[i] = to_next[i-1];
      assign inc_data[i]  = stage_next_data[(i-1)*W +: W];
    end

    pipe_stage_reg #(
      .W (W)
    ) u_reg (
      .clk      (clk),
      .reset    (reset),
      .squash   (squash[i]),
      .allowin  (allowin[i]),
      .in_valid (inc_valid[i]),
      .in_data  (inc_data[i]),
      .valid    (stage_valid[i]),
      .data     (stage_data[i*W +: W])
    );
  end

`ifdef PIPE_PERF_CNT_EN
  // Count blocked-but-not-squashed cycles per stage and effective flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (stage_valid[i] && !allowin[i] && !squash[i]) begin
          perf_stall_cnt[i*32 +: 32] <=
            perf_stall_cnt[i*32 +: 32] + 32'd1;
        end
      end
      if (|(stage_valid & squash)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed and randomized bench for pipe_chain against a
// behavioural stage-array model; PIPE_PERF_CNT_EN also checks counters.
module tb_pipe_chain;

  localparam int NS = 5;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   ready_go;
  logic [NS*W-1:0] snd;
  logic [NS-1:0]   sv;
  logic [NS*W-1:0] sd;
  logic            rv;
  logic [2:0]      rs;
  logic            xform = 1'b0;
`ifdef PIPE_PERF_CNT_EN
  logic [NS*32-1:0] p_stall;
  logic [31:0]      p_flush;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pipe_chain_if #(.W(W)) in_if ();
  pipe_chain_if #(.W(W)) out_if ();

  pipe_chain #(
    .NSTAGE (NS),
    .W      (W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_if           (in_if),
    .ready_go        (ready_go),
    .stage_next_data (snd),
    .stage_valid     (sv),
    .stage_data      (sd),
    .redirect_valid  (rv),
    .redirect_stage  (rs),
    .out_if          (out_if)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt  (p_stall),
    .perf_flush_cnt  (p_flush)
`endif
  );

  function automatic logic [W-1:0] nxt(int i, logic [W-1:0] x);
    return xform ? x + W'(i + 1) : x;
  endfunction

  // Stage logic stand-in: each stage's next payload from its latched one.
  always_comb begin
    snd = '0;
    for (int i = 0; i < NS; i++)
      snd[i*W +: W] = nxt(i, sd[i*W +: W]);
  end

  logic         mv [NS];
  logic [W-1:0] md [NS];
  logic [31:0]  mstall [NS];
  logic [31:0]  mflush;

  function automatic logic [NS:0] m_allow();
    logic [NS:0] a;
    a[NS] = out_if.allowin;
    for (int i = NS - 1; i >= 0; i--)
      a[i] = !mv[i] || (ready_go[i] && a[i+1]);
    return a;
  endfunction

  always @(posedge clk) begin : mdl
    logic [NS:0]  al;
    logic         nv [NS];
    logic [W-1:0] nd [NS];
    logic         inc;
    logic         any;
    int           k;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        mv[i] = 1'b0; md[i] = '0; mstall[i] = '0;
      end
      mflush = '0;
    end else begin
      al  = m_allow();
      k   = (int'(rs) >= NS) ? NS - 1 : int'(rs);
      any = 1'b0;
      for (int i = 0; i < NS; i++) begin
        nv[i] = mv[i];
        nd[i] = md[i];
        if (rv && i < k) begin
          nv[i] = 1'b0;
          if (mv[i]) any = 1'b1;
        end else begin
          if (mv[i] && !al[i]) mstall[i] = mstall[i] + 1;
          if (al[i]) begin
            inc = (i == 0) ? (in_if.valid && !rv)
                           : (mv[i-1] && ready_go[i-1]);
            nv[i] = inc;
            if (inc)
              nd[i] = (i == 0) ? in_if.data : nxt(i - 1, md[i-1]);
          end
        end
      end
      if (any) mflush = mflush + 1;
      for (int i = 0; i < NS; i++) begin
        mv[i] = nv[i];
        md[i] = nd[i];
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle it is out of reset.
  always @(negedge clk) begin : cmp
    logic [NS:0] al;
    logic        ov;
    if (reset === 1'b0) begin
      al = m_allow();
      ov = mv[NS-1] && ready_go[NS-1];
      chk("m_in_allowin", {31'b0, in_if.allowin}, {31'b0, al[0]});
      chk("m_out_valid", {31'b0, out_if.valid}, {31'b0, ov});
      if (ov) chk("m_out_data", out_if.data, nxt(NS - 1, md[NS-1]));
      for (int i = 0; i < NS; i++) begin
        chk($sformatf("m_valid%0d", i), {31'b0, sv[i]}, {31'b0, mv[i]});
        if (mv[i])
          chk($sformatf("m_data%0d", i), sd[i*W +: W], md[i]);
`ifdef PIPE_PERF_CNT_EN
        chk($sformatf("m_stall%0d", i), p_stall[i*32 +: 32], mstall[i]);
`endif
      end
`ifdef PIPE_PERF_CNT_EN
      chk("m_flush", p_flush, mflush);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_if.valid    = 1'b0;
    in_if.data     = '0;
    ready_go       = '1;
    out_if.allowin = 1'b1;
    rv             = 1'b0;
    rs             = '0;
  endtask

  task automatic feed(logic [W-1:0] base, int n);
    for (int j = 0; j < n; j++) begin
      in_if.valid = 1'b1;
      in_if.data  = base + W'(j);
      tick();
    end
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (8) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", {27'b0, sv}, 32'h0);
    chk("rst_data", {31'b0, sd == '0}, 32'h1);
    chk("rst_allowin", {31'b0, in_if.allowin}, 32'h1);
    chk("rst_out_valid", {31'b0, out_if.valid}, 32'h0);

    // Streaming: first accept at e1 leaves stage 4 after e5.
    feed(32'h100, 0);
    in_if.valid = 1'b1; in_if.data = 32'h100; tick();
    chk("str_allowin", {31'b0, in_if.allowin}, 32'h1);
    in_if.data = 32'h104; tick();
    chk("str_allowin", {31'b0, in_if.allowin}, 32'h1);
    in_if.data = 32'h108; tick();
    in_if.valid = 1'b0;
    tick(); tick(); #1;
    chk("str_ov0", {31'b0, out_if.valid}, 32'h1);
    chk("str_od0", out_if.data, 32'h100);
    tick(); chk("str_od1", out_if.data, 32'h104);
    tick(); chk("str_od2", out_if.data, 32'h108);
    tick(); chk("str_ov3", {31'b0, out_if.valid}, 32'h0);
    drain();

    // Stall at stage 2 for three cycles with a full pipe.
    feed(32'h10, 5);
    ready_go[2] = 1'b0;
    #1;
    chk("stl_allowin", {31'b0, in_if.allowin}, 32'h0);
    repeat (3) begin
      tick();
      chk("stl_bubble3", {31'b0, sv[3]}, 32'h0);
      chk("stl_hold2", sd[2*W +: W], 32'h12);
      chk("stl_allowin", {31'b0, in_if.allowin}, 32'h0);
    end
    ready_go[2] = 1'b1;
    tick();
    chk("stl_resume_v", {31'b0, sv[3]}, 32'h1);
    chk("stl_resume_d", sd[3*W +: W], 32'h12);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall0", p_stall[0 +: 32], 32'd3);
    chk("perf_stall1", p_stall[32 +: 32], 32'd3);
    chk("perf_stall2", p_stall[64 +: 32], 32'd3);
    chk("perf_stall3", p_stall[96 +: 32], 32'd0);
`endif
    drain();

    // Redirect from stage 2 squashes stages 0..1 and blocks input.
    feed(32'hA0, 3);
    in_if.valid = 1'b1; in_if.data = 32'h200;
    rv = 1'b1; rs = 3'd2;
    tick();
    idle(); #1;
    chk("rdr_v0", {31'b0, sv[0]}, 32'h0);
    chk("rdr_v1", {31'b0, sv[1]}, 32'h0);
    chk("rdr_v3", {31'b0, sv[3]}, 32'h1);
    chk("rdr_d3", sd[3*W +: W], 32'hA0);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_flush", p_flush, 32'd1);
`endif
    drain();

    // Redirect at stage 0 squashes nothing yet still refuses input.
    in_if.valid = 1'b1; in_if.data = 32'h300;
    rv = 1'b1; rs = 3'd0;
    tick();
    idle(); #1;
    chk("rdr0_valid", {27'b0, sv}, 32'h0);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_flush_k0", p_flush, 32'd1);
`endif

    // Consumer backpressure on a full pipe, then drain one per cycle.
    feed(32'h30, 5);
    out_if.allowin = 1'b0;
    repeat (4) begin
      #1;
      chk("bp_ov", {31'b0, out_if.valid}, 32'h1);
      chk("bp_od", out_if.data, 32'h30);
      chk("bp_sv", {27'b0, sv}, 32'h1f);
      chk("bp_allowin", {31'b0, in_if.allowin}, 32'h0);
      tick();
    end
    out_if.allowin = 1'b1;
    tick(); chk("bp_dr1", out_if.data, 32'h31);
    tick(); chk("bp_dr2", out_if.data, 32'h32);
    drain();

    // Reset in the middle of traffic clears everything in one cycle.
    feed(32'h40, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("mrst_valid", {27'b0, sv}, 32'h0);
    chk("mrst_data", {31'b0, sd == '0}, 32'h1);
    chk("mrst_allowin", {31'b0, in_if.allowin}, 32'h1);

    // Randomized traffic against the model, with a payload transform.
    xform = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      in_if.valid    = 1'($urandom_range(0, 1));
      in_if.data     = $urandom;
      for (int i = 0; i < NS; i++)
        ready_go[i] = ($urandom_range(0, 3) != 0);
      out_if.allowin = ($urandom_range(0, 3) != 0);
      rv             = ($urandom_range(0, 9) == 0);
      rs             = 3'($urandom_range(0, 7));
      reset          = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
